dma_copy_engine: RTL
====================

// Module: dma_copy_engine
// PURPOSE
//  Bus initiator that copies a block of memory by mastering load_interface and store_interface
//  (initiator side of the channels served by system memory). Lives in the system wrapper beside
//  the CPU; lets firmware or a bench move data without core involvement. Loads run ahead into a
//  small FIFO so loads and stores overlap.
// PARAMETERS
//  BUFFER_DEPTH  4   FIFO entries (power of 2, >=2); caps loads in flight plus buffered data
//  LEN_WIDTH     16  width of the transfer-count register
// PORTS
//  clk_i          in   1         clock
//  rst_n_i        in   1         reset, asynchronous, active-low
//  start_i        in   1         one-cycle pulse; latches src/dst/length/width; ignored while busy_o
//  abort_i        in   1         stop issuing, drain outstanding transactions, finish
//  src_address_i  in   32        source byte address
//  dst_address_i  in   32        destination byte address
//  length_i       in   LEN_WIDTH number of transfers (elements of width_i, not bytes)
//  width_i        in   2         BYTE / HALF_WORD / WORD (shared memory width enum)
//  busy_o         out  1         high from cycle after accepted start until done_o
//  done_o         out  1         one-cycle pulse at end of job (normal, abort or error)
//  error_o        out  1         sticky: misaligned src/dst on start; cleared by next start
//  aborted_o      out  1         sticky: last job ended by abort_i; cleared by next start
//  load_channel   master load_interface  (address, request, width -> ; data, valid <-)
//  store_channel  master store_interface (address, data, width, request -> ; done <-)
// BEHAVIOUR
//  - Reset: busy_o, done_o, error_o, aborted_o = 0; both requests = 0; addresses/data = 0; FSM IDLE; FIFO empty.
//  - FSM: IDLE -start-> CHECK; CHECK -misaligned-> FINISH (error_o=1); CHECK -length 0-> FINISH;
//    CHECK -> COPY; COPY -all stores done-> FINISH; COPY -abort_i-> DRAIN; DRAIN -no outstanding-> FINISH;
//    FINISH -> IDLE, pulsing done_o for exactly that cycle. busy_o high in CHECK/COPY/DRAIN.
//  - Misaligned: HALF_WORD with addr[0]!=0, WORD with addr[1:0]!=0 (src or dst). No bus traffic issued.
//  - Channel protocol: request is a single-cycle pulse, address/data/width valid that cycle;
//    responder answers valid/done exactly 1 cycle later. Max one outstanding per channel.
//  - Never assert load and store request in the same cycle (responder shares one memory port).
//  - Load eligible: COPY, loads_issued < length, no load outstanding, fifo_count + load_outstanding < BUFFER_DEPTH.
//    Store eligible: COPY or DRAIN-excluded (stores stop on abort), FIFO non-empty, no store outstanding.
//    Both eligible: store wins if fifo_count + load_outstanding == BUFFER_DEPTH, else round-robin
//    (last granted loses).
//  - Load valid pushes load_channel.data into FIFO same cycle; push when full is impossible by construction
//    (assert). Store issue pops FIFO head.
//  - Addresses: src/dst advance by 1/2/4 bytes after each issue; 32-bit wrap at 0xFFFFFFFF -> 0 is legal.
//  - Lane alignment: store data = FIFO word rotated left by 8*((dst - src) mod 4) bits, using the
//    per-element offsets (src[1:0], dst[1:0] of that element), so byte lane src[1:0] lands on lane dst[1:0].
//  - Completion: COPY -> FINISH when stores_done == length and no store outstanding.
//  - Abort: in CHECK -> FINISH directly; in COPY -> DRAIN: no new requests; wait outstanding valid/done;
//    drop returned data; flush FIFO; aborted_o=1. abort_i in IDLE/FINISH ignored.
//  - start_i and abort_i same cycle in IDLE: start accepted, abort ignored.
//  - Asynchronous reset mid-job: everything returns to reset values immediately; late valid/done ignored.
// STRUCTURE
//  - Package dma_pkg: dma_state_t enum {IDLE, CHECK, COPY, DRAIN, FINISH}; function width_bytes(width)
//    -> 1/2/4; function misaligned(addr, width).
//  - Sub-module dma_buffer_fifo #(DEPTH, 32): sync FIFO, async reset, push/pop/full/empty/count,
//    simultaneous push+pop allowed when non-empty.
//  - Top: FSM, issue counters (loads_issued, stores_done), arbiter, address regs, rotator.
// TESTING
//  - WORD copy 8 from 0x100 to 0x200 -> 8 loads, 8 stores, dst words equal src, done_o once, no req overlap.
//  - BYTE copy 5 from 0x101 to 0x202 -> bytes at 0x202..0x206 = src 0x101..0x105, neighbours untouched.
//  - HALF_WORD start with src=0x103 -> error_o=1, done_o 2 cycles after start, zero requests issued.
//  - length_i=0 WORD -> done_o pulse, no requests, error_o=0, aborted_o=0.
//  - abort_i during WORD copy 16 after 3 stores -> no further requests after outstanding done, aborted_o=1,
//    exactly one done_o; restart copy 2 afterwards completes normally with both sticky flags cleared.
//  - Responder delays valid (bench stalls) with BUFFER_DEPTH=2 -> never >2 loads in flight+buffered; async
//    reset mid-copy -> all outputs 0 within same cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA copy engine: the memory access width
// encoding, the engine state encoding, and the address/lane helper functions.
package dma_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    COPY   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } dma_state_t;

  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      BYTE:      width_bytes = 3'd1;
      HALF_WORD: width_bytes = 3'd2;
      default:   width_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] width);
    case (width)
      BYTE:      misaligned = 1'b0;
      HALF_WORD: misaligned = addr[0];
      default:   misaligned = |addr[1:0];
    endcase
  endfunction

  // Rotate a word left by whole byte lanes.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] n);
    case (n)
      2'd0:    rotl_bytes = d;
      2'd1:    rotl_bytes = {d[23:0], d[31:24]};
      2'd2:    rotl_bytes = {d[15:0], d[31:16]};
      default: rotl_bytes = {d[7:0],  d[31:8]};
    endcase
  endfunction

endpackage

// File: rtl/dma_copy_engine_fifo.sv
// Synchronous FIFO buffering load data ahead of the store side; supports
// simultaneous push and pop and a synchronous flush.
module dma_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Load issue is throttled by count + outstanding, so a push never meets a full FIFO.
  assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push_i && full_o));

endmodule

// File: rtl/dma_copy_engine.sv
// Block-copy bus initiator: loads run ahead into a small FIFO, stores drain it
// with byte-lane rotation; one memory port is shared so load and store never coincide.
//
// state  | meaning
// IDLE   | waiting for start_i
// CHECK  | alignment / zero-length / early-abort check on latched job
// COPY   | issuing loads and stores
// DRAIN  | aborted: wait for outstanding responses, FIFO flushed
// FINISH | done_o pulse, back to IDLE
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [31:0]          src_address_i,
  input  logic [31:0]          dst_address_i,
  input  logic [LEN_WIDTH-1:0] length_i,
  input  logic [1:0]           width_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 aborted_o,
  output logic [31:0]          load_address_o,
  output logic                 load_request_o,
  output logic [1:0]           load_width_o,
  input  logic [31:0]          load_data_i,
  input  logic                 load_valid_i,
  output logic [31:0]          store_address_o,
  output logic [31:0]          store_data_o,
  output logic [1:0]           store_width_o,
  output logic                 store_request_o,
  input  logic                 store_done_i
);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  dma_state_t           r_state;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [1:0]           r_src_lane;
  logic [1:0]           r_width;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_loads_issued;
  logic [LEN_WIDTH-1:0] r_stores_done;
  logic                 r_load_out;
  logic                 r_store_out;
  logic                 r_last_store;
  logic                 r_error;
  logic                 r_aborted;

  logic                 w_push;
  logic                 w_flush;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_inflight;
  logic [31:0]          w_head;
  logic [31:0]          w_step;
  logic                 w_load_elig;
  logic                 w_store_elig;
  logic                 w_load_gnt;
  logic                 w_store_gnt;

  dma_buffer_fifo #(.DEPTH(BUFFER_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .pop_i   (w_store_gnt),
    .flush_i (w_flush),
    .data_i  (load_data_i),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign w_step     = {29'd0, width_bytes(r_width)};
  assign w_inflight = w_count + {{(CW-1){1'b0}}, r_load_out};
  assign w_push     = r_load_out && load_valid_i && (r_state == COPY) && !w_full;
  assign w_flush    = (r_state == DRAIN);

  assign w_load_elig  = (r_state == COPY) && !abort_i && (r_loads_issued < r_len) &&
                        !r_load_out && (w_inflight < CW'(BUFFER_DEPTH));
  assign w_store_elig = (r_state == COPY) && !abort_i && !w_empty && !r_store_out;

  always_comb begin
    w_load_gnt  = 1'b0;
    w_store_gnt = 1'b0;
    if (w_load_elig && w_store_elig) begin
      if (w_inflight == CW'(BUFFER_DEPTH)) w_store_gnt = 1'b1;
      else if (r_last_store)               w_load_gnt  = 1'b1;
      else                                 w_store_gnt = 1'b1;
    end else begin
      w_load_gnt  = w_load_elig;
      w_store_gnt = w_store_elig;
    end
  end

  assign load_request_o  = w_load_gnt;
  assign load_address_o  = r_src;
  assign load_width_o    = r_width;
  assign store_request_o = w_store_gnt;
  assign store_address_o = r_dst;
  assign store_width_o   = r_width;
  // Source lane of the element at the FIFO head lands on its destination lane.
  assign store_data_o    = w_store_gnt ? rotl_bytes(w_head, r_dst[1:0] - r_src_lane) : 32'd0;

  assign busy_o    = (r_state == CHECK) || (r_state == COPY) || (r_state == DRAIN);
  assign done_o    = (r_state == FINISH);
  assign error_o   = r_error;
  assign aborted_o = r_aborted;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= IDLE;
      r_src          <= '0;
      r_dst          <= '0;
      r_src_lane     <= '0;
      r_width        <= '0;
      r_len          <= '0;
      r_loads_issued <= '0;
      r_stores_done  <= '0;
      r_load_out     <= 1'b0;
      r_store_out    <= 1'b0;
      r_last_store   <= 1'b0;
      r_error        <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      if (w_load_gnt)        r_load_out <= 1'b1;
      else if (load_valid_i) r_load_out <= 1'b0;
      if (w_store_gnt)       r_store_out <= 1'b1;
      else if (store_done_i) r_store_out <= 1'b0;

      if (w_load_gnt) begin
        r_src          <= r_src + w_step;
        r_loads_issued <= r_loads_issued + LEN_WIDTH'(1);
        r_last_store   <= 1'b0;
      end
      if (w_store_gnt) begin
        r_dst          <= r_dst + w_step;
        r_src_lane     <= r_src_lane + w_step[1:0];
        r_last_store   <= 1'b1;
      end
      if (r_store_out && store_done_i) r_stores_done <= r_stores_done + LEN_WIDTH'(1);

      case (r_state)
        IDLE: if (start_i) begin
          r_src          <= src_address_i;
          r_dst          <= dst_address_i;
          r_src_lane     <= src_address_i[1:0];
          r_width        <= width_i;
          r_len          <= length_i;
          r_loads_issued <= '0;
          r_stores_done  <= '0;
          r_last_store   <= 1'b0;
          r_error        <= 1'b0;
          r_aborted      <= 1'b0;
          r_state        <= CHECK;
        end
        CHECK: begin
          if (misaligned(r_src, r_width) || misaligned(r_dst, r_width)) begin
            r_error <= 1'b1;
            r_state <= FINISH;
          end else if (abort_i) begin
            r_aborted <= 1'b1;
            r_state   <= FINISH;
          end else if (r_len == '0) begin
            r_state <= FINISH;
          end else begin
            r_state <= COPY;
          end
        end
        COPY: begin
          if (abort_i) begin
            r_aborted <= 1'b1;
            r_state   <= DRAIN;
          end else if ((r_stores_done == r_len) && !r_store_out) begin
            r_state <= FINISH;
          end
        end
        DRAIN:   if (!r_load_out && !r_store_out) r_state <= FINISH;
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
